// File: rtl/csr_access_ctrl_pkg.sv
// Shared definitions for the CSR access controller: FSM encoding, RMW op codes,
// and the machine-mode CSR addresses the trap sequence touches.
package csr_access_ctrl_pkg;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_EX_RD    = 3'd1;
    localparam logic [2:0] S_EX_WR    = 3'd2;
    localparam logic [2:0] S_TR_EPC   = 3'd3;
    localparam logic [2:0] S_TR_CAUSE = 3'd4;
    localparam logic [2:0] S_TR_TVAL  = 3'd5;
    localparam logic [2:0] S_TR_VEC   = 3'd6;
    localparam logic [2:0] S_TR_ACK   = 3'd7;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csr_op_e;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] CSR_MTVAL  = 12'h343;

    function automatic logic [31:0] align4(input logic [31:0] v);
        return {v[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/csr_access_if.sv
// Execute-stage, trap-entry and CSR register-file signals of the controller.
// master = pipeline/register-file side, slave = the controller.
interface csr_access_if;
    logic        ex_req_i;
    logic [1:0]  ex_op_i;
    logic [11:0] ex_addr_i;
    logic [31:0] ex_src_i;
    logic        ex_ack_o;
    logic [31:0] ex_rdata_o;
    logic        ex_err_o;

    logic        trap_req_i;
    logic [31:0] trap_pc_i;
    logic [31:0] trap_cause_i;
    logic [31:0] trap_tval_i;
    logic        trap_ack_o;
    logic [31:0] trap_vec_o;

    logic [11:0] csr_addr_o;
    logic        csr_we_o;
    logic [31:0] csr_wdata_o;
    logic [31:0] csr_rdata_i;

    logic        busy_o;

    modport master (
        output ex_req_i, ex_op_i, ex_addr_i, ex_src_i,
        output trap_req_i, trap_pc_i, trap_cause_i, trap_tval_i,
        output csr_rdata_i,
        input  ex_ack_o, ex_rdata_o, ex_err_o, trap_ack_o, trap_vec_o,
        input  csr_addr_o, csr_we_o, csr_wdata_o, busy_o
    );

    modport slave (
        input  ex_req_i, ex_op_i, ex_addr_i, ex_src_i,
        input  trap_req_i, trap_pc_i, trap_cause_i, trap_tval_i,
        input  csr_rdata_i,
        output ex_ack_o, ex_rdata_o, ex_err_o, trap_ack_o, trap_vec_o,
        output csr_addr_o, csr_we_o, csr_wdata_o, busy_o
    );
endinterface

// File: rtl/csr_access_ctrl_rmw_alu.sv
// Combinational read-modify-write datapath for CSRRW/CSRRS/CSRRC: write data,
// write enable, and the illegal-write flag for the read-only address space.
module csr_rmw_alu
    import csr_access_ctrl_pkg::*;
(
    input  csr_op_e     op_i,
    input  logic [31:0] old_i,
    input  logic [31:0] src_i,
    input  logic        ro_i,
    output logic [31:0] wdata_o,
    output logic        we_o,
    output logic        illegal_o
);

    logic wants_write;

    always_comb begin
        wdata_o     = src_i;
        wants_write = 1'b0;
        case (op_i)
            OP_RW: begin
                wdata_o     = src_i;
                wants_write = 1'b1;
            end
            OP_RS: begin
                wdata_o     = old_i | src_i;
                wants_write = (src_i != 32'd0);
            end
            OP_RC: begin
                wdata_o     = old_i & ~src_i;
                wants_write = (src_i != 32'd0);
            end
            default: wants_write = 1'b0;
        endcase
        // A set/clear with a zero mask is a pure read, so it never faults.
        we_o      = wants_write & ~ro_i;
        illegal_o = wants_write &  ro_i;
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// CSR access sequencer: serves execute-stage RMW requests and the trap-entry
// mepc/mcause/mtval write + mtvec read. Vectored mode under CSR_VEC_MODE_EN.
module csr_access_ctrl
    import csr_access_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    csr_access_if.slave  bus
);

    logic [2:0]  state_q, state_d;
    logic [31:0] alu_wdata;
    logic        alu_we;
    logic        alu_illegal;
    logic [31:0] trap_vec;
    logic        live;

    csr_rmw_alu u_alu (
        .op_i      (csr_op_e'(bus.ex_op_i)),
        .old_i     (bus.csr_rdata_i),
        .src_i     (bus.ex_src_i),
        .ro_i      (bus.ex_addr_i[11:10] == 2'b11),
        .wdata_o   (alu_wdata),
        .we_o      (alu_we),
        .illegal_o (alu_illegal)
    );

    always_comb begin
`ifdef CSR_VEC_MODE_EN
        if (bus.csr_rdata_i[1:0] == 2'b01 && bus.trap_cause_i[31])
            trap_vec = align4(bus.csr_rdata_i) + {25'd0, bus.trap_cause_i[4:0], 2'b00};
        else
            trap_vec = align4(bus.csr_rdata_i);
`else
        trap_vec = align4(bus.csr_rdata_i);
`endif
    end

    // A dropped request abandons its sequence; IDLE re-arbitrates next cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.trap_req_i)    state_d = S_TR_EPC;
                else if (bus.ex_req_i) state_d = S_EX_RD;
            end
            S_EX_RD:    state_d = bus.ex_req_i   ? S_EX_WR    : S_IDLE;
            S_EX_WR:    state_d = S_IDLE;
            S_TR_EPC:   state_d = bus.trap_req_i ? S_TR_CAUSE : S_IDLE;
            S_TR_CAUSE: state_d = bus.trap_req_i ? S_TR_TVAL  : S_IDLE;
            S_TR_TVAL:  state_d = bus.trap_req_i ? S_TR_VEC   : S_IDLE;
            S_TR_VEC:   state_d = bus.trap_req_i ? S_TR_ACK   : S_IDLE;
            S_TR_ACK:   state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Reset gates writes and acks in the cycle it is sampled, so an aborted
    // sequence commits nothing further.
    assign live = ~rst;

    always_comb begin
        bus.ex_ack_o    = 1'b0;
        bus.ex_rdata_o  = 32'd0;
        bus.ex_err_o    = 1'b0;
        bus.trap_ack_o  = 1'b0;
        bus.trap_vec_o  = 32'd0;
        bus.csr_addr_o  = 12'd0;
        bus.csr_we_o    = 1'b0;
        bus.csr_wdata_o = 32'd0;
        case (state_q)
            S_EX_RD: bus.csr_addr_o = bus.ex_addr_i;
            S_EX_WR: begin
                bus.csr_addr_o = bus.ex_addr_i;
                if (bus.ex_req_i && live) begin
                    bus.ex_ack_o    = 1'b1;
                    bus.ex_rdata_o  = bus.csr_rdata_i;
                    bus.ex_err_o    = alu_illegal;
                    bus.csr_we_o    = alu_we;
                    bus.csr_wdata_o = alu_wdata;
                end
            end
            S_TR_EPC: begin
                bus.csr_addr_o  = CSR_MEPC;
                bus.csr_wdata_o = align4(bus.trap_pc_i);
                bus.csr_we_o    = bus.trap_req_i & live;
            end
            S_TR_CAUSE: begin
                bus.csr_addr_o  = CSR_MCAUSE;
                bus.csr_wdata_o = bus.trap_cause_i;
                bus.csr_we_o    = bus.trap_req_i & live;
            end
            S_TR_TVAL: begin
                bus.csr_addr_o  = CSR_MTVAL;
                bus.csr_wdata_o = bus.trap_tval_i;
                bus.csr_we_o    = bus.trap_req_i & live;
            end
            S_TR_VEC: bus.csr_addr_o = CSR_MTVEC;
            S_TR_ACK: begin
                bus.csr_addr_o = CSR_MTVEC;
                if (bus.trap_req_i && live) begin
                    bus.trap_ack_o = 1'b1;
                    bus.trap_vec_o = trap_vec;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy_o = (state_q != S_IDLE);

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR register file
// (one-cycle read latency) and hand-computed expectations.
module tb_csr_access_ctrl;
    import csr_access_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_access_if bus();

    csr_access_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [31:0] rf [0:4095];
    logic [31:0] rdata_q;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;

    always @(posedge clk) begin
        if (bus.csr_we_o === 1'b1) rf[bus.csr_addr_o] <= bus.csr_wdata_o;
        if (bd_we) rf[bd_addr] <= bd_data;
        rdata_q <= rf[bus.csr_addr_o];
    end
    assign bus.csr_rdata_i = rdata_q;

    int cyc = 0;
    int we_cnt = 0;
    int tack_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.csr_we_o === 1'b1)   we_cnt++;
        if (bus.trap_ack_o === 1'b1) tack_cnt++;
    end

    int n_cmp = 0;
    int n_fail = 0;

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    // Raise the selected requests in cycle C and hold each until its ack edge.
    task automatic run_seq(input bit do_ex, input bit do_tr,
                           output int t_lat, output int e_lat,
                           output logic [31:0] rdata, output logic err,
                           output logic [31:0] vec);
        int c0;
        bit tr_done, ex_done;
        t_lat = -1; e_lat = -1; rdata = '0; err = 1'b0; vec = '0;
        @(negedge clk);
        c0 = cyc;
        bus.ex_req_i = do_ex; bus.trap_req_i = do_tr;
        tr_done = !do_tr; ex_done = !do_ex;
        for (int n = 0; n < 20 && !(tr_done && ex_done); n++) begin
            if (n > 0) @(negedge clk);
            if (bus.trap_ack_o === 1'b1) begin
                t_lat = cyc - c0; vec = bus.trap_vec_o; tr_done = 1'b1;
            end
            if (bus.ex_ack_o === 1'b1) begin
                e_lat = cyc - c0; rdata = bus.ex_rdata_o; err = bus.ex_err_o; ex_done = 1'b1;
            end
            @(posedge clk); #1;
            if (tr_done) bus.trap_req_i = 1'b0;
            if (ex_done) bus.ex_req_i = 1'b0;
        end
        bus.ex_req_i = 1'b0; bus.trap_req_i = 1'b0;
    endtask

    int t_lat, e_lat, w0, k0;
    logic [31:0] rd, vec;
    logic er;

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b want=0", bus.busy_o); end
        n_cmp++; if (bus.ex_ack_o !== 1'b0 || bus.trap_ack_o !== 1'b0) begin n_fail++; $display("FAIL reset_acks got=%0b%0b want=00", bus.ex_ack_o, bus.trap_ack_o); end
        n_cmp++; if (bus.csr_we_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b want=0", bus.csr_we_o); end
        n_cmp++; if (bus.csr_addr_o !== 12'd0 || bus.csr_wdata_o !== 32'd0) begin n_fail++; $display("FAIL reset_bus addr=%h wdata=%h want 0", bus.csr_addr_o, bus.csr_wdata_o); end
        n_cmp++; if (bus.ex_rdata_o !== 32'd0 || bus.ex_err_o !== 1'b0 || bus.trap_vec_o !== 32'd0) begin n_fail++; $display("FAIL reset_data rdata=%h err=%0b vec=%h want 0", bus.ex_rdata_o, bus.ex_err_o, bus.trap_vec_o); end
        rst = 1'b0;
    endtask

    task automatic test_rw();
        poke(12'h340, 32'h0000_1234);
        bus.ex_op_i = OP_RW; bus.ex_addr_i = 12'h340; bus.ex_src_i = 32'hA5A5_0000;
        run_seq(1'b1, 1'b0, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (e_lat !== 2) begin n_fail++; $display("FAIL rw_latency got=%0d want=2", e_lat); end
        n_cmp++; if (rd !== 32'h0000_1234) begin n_fail++; $display("FAIL rw_rdata got=%h want=00001234", rd); end
        n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL rw_err got=%0b want=0", er); end
        n_cmp++; if (rf[12'h340] !== 32'hA5A5_0000) begin n_fail++; $display("FAIL rw_mscratch got=%h want=a5a50000", rf[12'h340]); end
    endtask

    task automatic test_rs_rc();
        poke(12'h304, 32'h0000_0088);
        bus.ex_addr_i = 12'h304;
        bus.ex_op_i = OP_RS; bus.ex_src_i = 32'd0;
        w0 = we_cnt;
        run_seq(1'b1, 1'b0, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (we_cnt - w0 !== 0) begin n_fail++; $display("FAIL rs0_writes got=%0d want=0", we_cnt - w0); end
        n_cmp++; if (rd !== 32'h88 || rf[12'h304] !== 32'h88) begin n_fail++; $display("FAIL rs0_value rdata=%h mie=%h want=88/88", rd, rf[12'h304]); end
        bus.ex_op_i = OP_RC; bus.ex_src_i = 32'h08;
        run_seq(1'b1, 1'b0, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (rf[12'h304] !== 32'h80) begin n_fail++; $display("FAIL rc_mie got=%h want=80", rf[12'h304]); end
        n_cmp++; if (rd !== 32'h88 || e_lat !== 2) begin n_fail++; $display("FAIL rc_ack rdata=%h lat=%0d want=88/2", rd, e_lat); end
        bus.ex_op_i = OP_RS; bus.ex_src_i = 32'h100;
        run_seq(1'b1, 1'b0, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (rf[12'h304] !== 32'h180) begin n_fail++; $display("FAIL rs_mie got=%h want=180", rf[12'h304]); end
    endtask

    task automatic test_readonly();
        poke(12'hF14, 32'h0000_ABCD);
        bus.ex_op_i = OP_RW; bus.ex_addr_i = 12'hF14; bus.ex_src_i = 32'h55;
        w0 = we_cnt;
        run_seq(1'b1, 1'b0, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (er !== 1'b1 || e_lat !== 2) begin n_fail++; $display("FAIL ro_err err=%0b lat=%0d want=1/2", er, e_lat); end
        n_cmp++; if (we_cnt - w0 !== 0 || rf[12'hF14] !== 32'hABCD) begin n_fail++; $display("FAIL ro_nowrite writes=%0d val=%h want=0/abcd", we_cnt - w0, rf[12'hF14]); end
        n_cmp++; if (rd !== 32'hABCD) begin n_fail++; $display("FAIL ro_rdata got=%h want=abcd", rd); end
        bus.ex_op_i = OP_RS; bus.ex_src_i = 32'd0;
        run_seq(1'b1, 1'b0, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (er !== 1'b0 || e_lat !== 2) begin n_fail++; $display("FAIL ro_read err=%0b lat=%0d want=0/2", er, e_lat); end
    endtask

    task automatic test_trap();
        poke(CSR_MTVEC, 32'h100);
        bus.trap_pc_i = 32'h8000_0106; bus.trap_cause_i = 32'h2; bus.trap_tval_i = 32'hDEAD;
        run_seq(1'b0, 1'b1, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (t_lat !== 5) begin n_fail++; $display("FAIL trap_latency got=%0d want=5", t_lat); end
        n_cmp++; if (vec !== 32'h100) begin n_fail++; $display("FAIL trap_vec got=%h want=100", vec); end
        n_cmp++; if (rf[CSR_MEPC] !== 32'h8000_0104) begin n_fail++; $display("FAIL trap_mepc got=%h want=80000104", rf[CSR_MEPC]); end
        n_cmp++; if (rf[CSR_MCAUSE] !== 32'h2 || rf[CSR_MTVAL] !== 32'hDEAD) begin n_fail++; $display("FAIL trap_cause_tval got=%h/%h want=2/dead", rf[CSR_MCAUSE], rf[CSR_MTVAL]); end
    endtask

    task automatic test_priority();
        poke(12'h340, 32'h0000_0077);
        bus.ex_op_i = OP_RW; bus.ex_addr_i = 12'h340; bus.ex_src_i = 32'h0000_0099;
        bus.trap_pc_i = 32'h200; bus.trap_cause_i = 32'h3; bus.trap_tval_i = 32'h0;
        run_seq(1'b1, 1'b1, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (t_lat !== 5) begin n_fail++; $display("FAIL prio_trap_latency got=%0d want=5", t_lat); end
        n_cmp++; if (e_lat !== 8) begin n_fail++; $display("FAIL prio_ex_latency got=%0d want=8", e_lat); end
        n_cmp++; if (rd !== 32'h77 || rf[12'h340] !== 32'h99) begin n_fail++; $display("FAIL prio_ex_data rdata=%h mscratch=%h want=77/99", rd, rf[12'h340]); end
    endtask

    task automatic test_vector();
        logic [31:0] exp_vec;
`ifdef CSR_VEC_MODE_EN
        exp_vec = 32'h21C;
`else
        exp_vec = 32'h200;
`endif
        poke(CSR_MTVEC, 32'h201);
        bus.trap_pc_i = 32'h300; bus.trap_cause_i = 32'h8000_0007; bus.trap_tval_i = 32'h0;
        run_seq(1'b0, 1'b1, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (vec !== exp_vec || t_lat !== 5) begin n_fail++; $display("FAIL vec_interrupt got=%h lat=%0d want=%h/5", vec, t_lat, exp_vec); end
        bus.trap_cause_i = 32'h2;
        run_seq(1'b0, 1'b1, t_lat, e_lat, rd, er, vec);
        n_cmp++; if (vec !== 32'h200) begin n_fail++; $display("FAIL vec_exception got=%h want=200", vec); end
    endtask

    task automatic test_reset_mid();
        poke(CSR_MEPC, 32'h0);
        poke(CSR_MCAUSE, 32'h0);
        poke(CSR_MTVAL, 32'h1111);
        bus.trap_pc_i = 32'h43; bus.trap_cause_i = 32'h5; bus.trap_tval_i = 32'h77;
        @(negedge clk);
        w0 = we_cnt; k0 = tack_cnt;
        bus.trap_req_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; bus.trap_req_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (rf[CSR_MEPC] !== 32'h40 || rf[CSR_MCAUSE] !== 32'h5) begin n_fail++; $display("FAIL midrst_committed mepc=%h mcause=%h want=40/5", rf[CSR_MEPC], rf[CSR_MCAUSE]); end
        n_cmp++; if (rf[CSR_MTVAL] !== 32'h1111 || we_cnt - w0 !== 2) begin n_fail++; $display("FAIL midrst_aborted mtval=%h writes=%0d want=1111/2", rf[CSR_MTVAL], we_cnt - w0); end
        n_cmp++; if (tack_cnt - k0 !== 0 || bus.busy_o !== 1'b0) begin n_fail++; $display("FAIL midrst_noack acks=%0d busy=%0b want=0/0", tack_cnt - k0, bus.busy_o); end
    endtask

    initial begin
        rst = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        bus.ex_req_i = 1'b0; bus.ex_op_i = 2'b00; bus.ex_addr_i = '0; bus.ex_src_i = '0;
        bus.trap_req_i = 1'b0; bus.trap_pc_i = '0; bus.trap_cause_i = '0; bus.trap_tval_i = '0;
        test_reset();
        test_rw();
        test_rs_rc();
        test_readonly();
        test_trap();
        test_priority();
        test_vector();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
